// File: rtl/tpu_host_master_if.sv
// Host-stream and TPU slave-port signals of tpu_host_master, bundled for port connection.
// master = the tpu_host_master side, slave = the host/TPU environment side.
interface tpu_host_master_if #(
  parameter int unsigned ADDRW = 16,
  parameter int unsigned DATAW = 64
) ();
  logic             start;
  logic             busy;
  logic             done;
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_din;
  logic [DATAW-1:0] tpu_dout;

  modport master (
    input  start, in_data, in_valid, out_ready, tpu_dout,
    output busy, done, in_ready, out_data, out_valid, tpu_r_w, tpu_addr, tpu_din
  );

  modport slave (
    output start, in_data, in_valid, out_ready, tpu_dout,
    input  busy, done, in_ready, out_data, out_valid, tpu_r_w, tpu_addr, tpu_din
  );
endinterface

// File: rtl/tpu_host_master.sv
// Streams A/B rows into the TPU slave port, kicks the matmul, waits, then streams C back.
// Optional busy-cycle counter output enabled by defining TPU_HOST_MASTER_PERF_EN.
module tpu_host_master #(
  parameter int unsigned BITS_AB   = 8,
  parameter int unsigned BITS_C    = 16,
  parameter int unsigned DIM       = 8,
  parameter int unsigned ADDRW     = 16,
  parameter int unsigned DATAW     = 64,
  parameter int unsigned MM_CYCLES = 24,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  tpu_host_master_if.master bus
`ifdef TPU_HOST_MASTER_PERF_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam int unsigned WPR = DIM * BITS_C / DATAW;
  localparam int unsigned RW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned WW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int unsigned TW  = $clog2(MM_CYCLES + 1);
  localparam int unsigned LW  = $clog2(RD_LAT + 1);

  localparam logic [ADDRW-1:0] A_BASE    = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE    = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE    = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] KICK_ADDR = ADDRW'(16'h0400);

  if ((DIM * BITS_AB != DATAW) || ((DIM * BITS_C) % DATAW != 0) ||
      (MM_CYCLES < 3 * DIM) || (RD_LAT < 1)) begin : g_bad_cfg
    $error("tpu_host_master: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_KICK, S_WAIT, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT
  } state_e;

  state_e          state_q;
  logic [RW-1:0]   r_q, r_d;
  logic [WW-1:0]   w_q, w_d;
  logic [TW-1:0]   t_q;
  logic [LW-1:0]   lat_q;
  logic            last_c;

  function automatic logic [ADDRW-1:0] c_addr(input logic [RW-1:0] r, input logic [WW-1:0] w);
    return C_BASE + (ADDRW'(r) << 4) + (ADDRW'(w) << 3);
  endfunction

  // Next C word position: w wraps at WPR and carries into r.
  always_comb begin
    r_d    = r_q;
    w_d    = w_q + WW'(1);
    last_c = (r_q == RW'(DIM - 1)) && (w_q == WW'(WPR - 1));
    if (w_q == WW'(WPR - 1)) begin
      w_d = '0;
      r_d = r_q + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      r_q           <= '0;
      w_q           <= '0;
      t_q           <= '0;
      lat_q         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.tpu_r_w   <= 1'b0;
      bus.tpu_addr  <= '0;
      bus.tpu_din   <= '0;
    end else begin
      bus.done    <= 1'b0;
      bus.tpu_r_w <= 1'b0;
      bus.tpu_din <= '0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q      <= S_LOAD_A;
            r_q          <= '0;
            bus.busy     <= 1'b1;
            bus.in_ready <= 1'b1;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.tpu_r_w  <= 1'b1;
            bus.tpu_addr <= ((state_q == S_LOAD_A) ? A_BASE : B_BASE) + (ADDRW'(r_q) << 3);
            bus.tpu_din  <= bus.in_data;
            if (r_q == RW'(DIM - 1)) begin
              r_q <= '0;
              if (state_q == S_LOAD_A) begin
                state_q <= S_LOAD_B;
              end else begin
                state_q      <= S_KICK;
                bus.in_ready <= 1'b0;
              end
            end else begin
              r_q <= r_q + RW'(1);
            end
          end
        end
        S_KICK: begin
          bus.tpu_r_w  <= 1'b1;
          bus.tpu_addr <= KICK_ADDR;
          t_q          <= '0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (t_q == TW'(MM_CYCLES - 1)) begin
            state_q      <= S_RD_ISSUE;
            r_q          <= '0;
            w_q          <= '0;
            bus.tpu_addr <= c_addr('0, '0);
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        S_RD_ISSUE: begin
          lat_q   <= '0;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // tpu_dout is valid RD_LAT cycles after the address first appeared (RD_ISSUE).
          if (lat_q == LW'(RD_LAT - 1)) begin
            bus.out_data  <= bus.tpu_dout;
            bus.out_valid <= 1'b1;
            state_q       <= S_RD_OUT;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        S_RD_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (last_c) begin
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              r_q          <= r_d;
              w_q          <= w_d;
              bus.tpu_addr <= c_addr(r_d, w_d);
              state_q      <= S_RD_ISSUE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef TPU_HOST_MASTER_PERF_EN
  logic [31:0] cyc_cnt_q;

  // Busy-cycle count of the latest job; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && bus.start) begin
      cyc_cnt_q <= '0;
    end else if (bus.busy && (cyc_cnt_q != 32'hFFFF_FFFF)) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end

  assign cycle_count = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_tpu_host_master.sv
// Scoreboard bench for tpu_host_master: expected bus writes and C words are queued at
// stimulus time and checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_tpu_host_master;
  localparam int unsigned DIM       = 8;
  localparam int unsigned ADDRW     = 16;
  localparam int unsigned DATAW     = 64;
  localparam int unsigned MM_CYCLES = 24;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned NOUT      = 16;
  localparam int unsigned NIN       = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_host_master_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

`ifdef TPU_HOST_MASTER_PERF_EN
  logic [31:0] cycle_count;
`endif

  tpu_host_master #(
    .BITS_AB(8), .BITS_C(16), .DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW),
    .MM_CYCLES(MM_CYCLES), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef TPU_HOST_MASTER_PERF_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  // TPU read model: data = address, one cycle after the address is presented.
  always_ff @(posedge clk) bus.tpu_dout <= DATAW'(bus.tpu_addr);

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data;
  } wr_t;

  wr_t              exp_wr[$];
  logic [DATAW-1:0] exp_out[$];
  int errors = 0;
  int checks = 0;

  int   mcyc = 0;
  int   kick_cyc = -1;
  int   first_rd_cyc = -1;
  int   done_cnt = 0;
  int   busy_cyc = 0;
  logic prev_busy = 1'b0;
  logic stall_prev = 1'b0;
  logic [DATAW-1:0] stall_data = '0;
  wr_t  mon_e;
  logic [DATAW-1:0] mon_o;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_busy  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      mcyc++;
      if (bus.tpu_r_w) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                   bus.tpu_addr, bus.tpu_din);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", 64'(bus.tpu_addr), 64'(mon_e.addr));
          chk("wr_data", bus.tpu_din, mon_e.data);
        end
        if (bus.tpu_addr == ADDRW'(16'h0400)) kick_cyc = mcyc;
      end else begin
        chk("idle_din", bus.tpu_din, 64'd0);
        if (kick_cyc >= 0 && first_rd_cyc < 0 && bus.tpu_addr == ADDRW'(16'h0300))
          first_rd_cyc = mcyc;
      end
      if (stall_prev && bus.out_valid) chk("stall_stable", bus.out_data, stall_data);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%0h expected none", bus.out_data);
        end else begin
          mon_o = exp_out.pop_front();
          chk("out_data", bus.out_data, mon_o);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      if (bus.done) begin
        done_cnt++;
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        chk("busy_before_done", 64'(prev_busy), 64'd1);
      end
      if (bus.busy) busy_cyc++;
      prev_busy = bus.busy;
    end
  end

  // abort_after > 0: stop after that many input handshakes and reset the DUT.
  task automatic run_job(input bit toggle, input bit stall, input int abort_after);
    int   idx = 0;
    int   n_out = 0;
    int   hold = 0;
    int   budget = 0;
    int   nwords;
    logic hs;
    wr_t  w;
    nwords = (abort_after > 0) ? abort_after : NIN;
    done_cnt = 0;
    kick_cyc = -1;
    first_rd_cyc = -1;
    busy_cyc = 0;
    if (abort_after == 0)
      for (int k = 0; k < NOUT; k++) exp_out.push_back(DATAW'(32'h0300 + 8 * k));

    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;

    while (idx < nwords && budget < 400) begin
      bus.in_data  = DATAW'(32'h0101 + idx);
      bus.in_valid = toggle ? ((budget % 2) == 1) : 1'b1;
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (hs) begin
        w.addr = (idx < 8) ? ADDRW'(32'h0100 + 8 * idx) : ADDRW'(32'h0200 + 8 * (idx - 8));
        w.data = DATAW'(32'h0101 + idx);
        exp_wr.push_back(w);
        idx++;
        if (idx == NIN) begin
          w.addr = ADDRW'(16'h0400);
          w.data = '0;
          exp_wr.push_back(w);
        end
      end
      budget++;
    end
    chk("in_words", 64'(idx), 64'(nwords));

    if (abort_after > 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      return;
    end

    // Surplus input and a start while busy must both be ignored.
    bus.in_data  = DATAW'(64'hDEAD);
    bus.in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b0;

    budget = 0;
    while (n_out < NOUT && budget < 2000) begin
      bus.out_ready = !(stall && n_out == 5 && hold < 10);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) n_out++;
      else if (bus.out_valid) hold++;
      @(posedge clk); #1;
      budget++;
    end
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("out_words", 64'(n_out), 64'(NOUT));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("wait_len", 64'(first_rd_cyc - kick_cyc), 64'(MM_CYCLES));
    chk("writes_left", 64'(exp_wr.size()), 64'd0);
    chk("outs_left", 64'(exp_out.size()), 64'd0);
    chk("busy_after", 64'(bus.busy), 64'd0);
    if (stall) chk("stall_len", 64'(hold), 64'd10);
`ifdef TPU_HOST_MASTER_PERF_EN
    chk("cycle_count", 64'(cycle_count), 64'(busy_cyc));
`endif
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_r_w", 64'(bus.tpu_r_w), 64'd0);
    chk("rst_addr", 64'(bus.tpu_addr), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);

    run_job(1'b0, 1'b0, 0);
    run_job(1'b1, 1'b1, 0);
    run_job(1'b0, 1'b0, 11);
    repeat (3) @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_pending", 64'(exp_wr.size()), 64'd0);
    run_job(1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
